lfsr_period_monitor: RTL and testbench

LFSR_PERIOD_MONITOR -- requirements
Module: lfsr_period_monitor

---
 rtl/lfsr_period_monitor_pkg.sv | 15 +
 rtl/lfsr_period_monitor_if.sv | 25 ++
 rtl/lfsr_period_monitor_sample_counter.sv | 29 ++
 rtl/lfsr_period_monitor.sv | 117 +++++++++++
 tb/tb_lfsr_period_monitor.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/lfsr_period_monitor_pkg.sv
// Shared FSM encoding and default sizing for the LFSR period monitor.
package lfsr_period_monitor_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_TIMEOUT = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_COUNT = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

endpackage

// File: rtl/lfsr_period_monitor_if.sv
// Sample stream in, measurement result out; the monitor is the slave side.
interface lfsr_period_monitor_if
    import lfsr_period_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] w;
    logic             w_valid;
    logic [WIDTH:0]   period;
    logic             done;
    logic             zero_lock;
    logic             timeout;
    logic             busy;

    modport master (
        output start, w, w_valid,
        input  period, done, zero_lock, timeout, busy
    );

    modport slave (
        input  start, w, w_valid,
        output period, done, zero_lock, timeout, busy
    );
endinterface

// File: rtl/lfsr_period_monitor_sample_counter.sv
// Valid-sample counter with synchronous clear/enable and a look-ahead terminal-count flag.
module sample_counter #(
    parameter int CW      = 5,
    parameter int TIMEOUT = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_next_o,
    output logic          tc_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    // The FSM leaves COUNT when cnt_next reaches TIMEOUT, so this never wraps.
    assign cnt_next_o = cnt_q + CW'(1);
    assign tc_o       = (cnt_next_o == CW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_next_o;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR word stream; flags all-zero lock-up and timeout.
module lfsr_period_monitor
    import lfsr_period_monitor_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    lfsr_period_monitor_if.slave   bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH:0]   period_q, period_d;
    logic             done_q, done_d, zl_q, zl_d, to_q, to_d, busy_q, busy_d;
    logic             cnt_clr, cnt_en, tc;
    logic [WIDTH:0]   cnt_next;
    logic             hit_zero, hit_ref, hit_to;

    sample_counter #(.CW(WIDTH + 1), .TIMEOUT(TIMEOUT)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .cnt_next_o (cnt_next),
        .tc_o       (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ref_q    <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
            zl_q     <= 1'b0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            period_q <= period_d;
            done_q   <= done_d;
            zl_q     <= zl_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
        end
    end

    // start outranks any same-cycle sample in every state.
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        hit_zero = 1'b0;
        hit_ref  = 1'b0;
        hit_to   = 1'b0;
        if (bus.start) begin
            state_d = ST_ARM;
            ref_d   = '0;
            cnt_clr = 1'b1;
        end else if (bus.w_valid) begin
            case (state_q)
                ST_ARM: begin
                    ref_d   = bus.w;
                    cnt_clr = 1'b1;
                    if (bus.w == '0) begin
                        state_d  = ST_FAIL;
                        hit_zero = 1'b1;
                    end else begin
                        state_d  = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    cnt_en = 1'b1;
                    if (bus.w == '0) begin
                        state_d  = ST_FAIL;
                        hit_zero = 1'b1;
                    end else if (bus.w == ref_q) begin
                        state_d  = ST_DONE;
                        hit_ref  = 1'b1;
                    end else if (tc) begin
                        state_d  = ST_FAIL;
                        hit_to   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        period_d = period_q;
        done_d   = done_q;
        zl_d     = zl_q;
        to_d     = to_q;
        busy_d   = (state_d == ST_ARM) || (state_d == ST_COUNT);
        if (state_d == ST_ARM) begin
            period_d = '0;
            done_d   = 1'b0;
            zl_d     = 1'b0;
            to_d     = 1'b0;
        end
        if (hit_ref) begin
            done_d   = 1'b1;
            period_d = cnt_next;
        end
        if (hit_zero) zl_d = 1'b1;
        if (hit_to)   to_d = 1'b1;
    end

    assign bus.period    = period_q;
    assign bus.done      = done_q;
    assign bus.zero_lock = zl_q;
    assign bus.timeout   = to_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench: sample-history model checked every cycle, plus literal result checks.
module tb_lfsr_period_monitor;
    localparam int W  = 4;
    localparam int TO = 31;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    lfsr_period_monitor_if #(.WIDTH(W)) bus ();

    lfsr_period_monitor #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: the list of valid samples since arming; entry 0 is the reference.
    logic [W-1:0] hist[$];
    bit           m_armed, m_done, m_zl, m_to, m_ready;
    int           m_period;

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                hist.delete();
                m_armed = 0; m_done = 0; m_zl = 0; m_to = 0; m_period = 0;
                m_ready = 1'b1;
            end else if (bus.start) begin
                hist.delete();
                m_armed = 1; m_done = 0; m_zl = 0; m_to = 0; m_period = 0;
            end else if (m_armed && bus.w_valid) begin
                hist.push_back(bus.w);
                if (bus.w == 0) begin
                    m_zl = 1; m_armed = 0;
                end else if (hist.size() > 1 && bus.w == hist[0]) begin
                    m_done = 1; m_period = hist.size() - 1; m_armed = 0;
                end else if (hist.size() - 1 == TO) begin
                    m_to = 1; m_armed = 0;
                end
            end
            #1;
            if (m_ready) begin
                tests++;
                if ({bus.period, bus.done, bus.zero_lock, bus.timeout, bus.busy} !==
                    {5'(m_period), m_done, m_zl, m_to, m_armed}) begin
                    fails++;
                    $display("FAIL model_cmp t=%0t got p=%0d d=%b z=%b t=%b b=%b exp p=%0d d=%b z=%b t=%b b=%b",
                             $time, bus.period, bus.done, bus.zero_lock, bus.timeout, bus.busy,
                             m_period, m_done, m_zl, m_to, m_armed);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [W-1:0] d);
        @(negedge clk);
        reset = r; bus.start = s; bus.w_valid = v; bus.w = d;
    endtask

    function automatic logic [W-1:0] lfsr_nxt(input logic [W-1:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    task automatic run_lfsr(input int n, input bit gap);
        logic [W-1:0] x = 4'hF;
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1, x);
            if (gap) step(0, 0, 0, 4'h0);
            x = lfsr_nxt(x);
        end
    endtask

    initial begin
        bus.start = 0; bus.w_valid = 0; bus.w = '0;
        step(1, 0, 0, 0); step(1, 1, 1, 4'h5);
        step(0, 0, 0, 0);
        chk("reset_outputs", {bus.period, bus.done, bus.zero_lock, bus.timeout, bus.busy}, 0);
        step(0, 0, 1, 4'h3); step(0, 0, 0, 0);
        chk("idle_ignores_w", bus.busy, 0);

        // maximal 4-bit LFSR from 1111
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        chk("arm_busy", bus.busy, 1);
        run_lfsr(16, 0); step(0, 0, 0, 0);
        chk("lfsr_done", bus.done, 1);
        chk("lfsr_period", bus.period, 15);
        chk("lfsr_flags", {bus.zero_lock, bus.timeout, bus.busy}, 0);
        step(0, 0, 1, 4'hF); step(0, 0, 0, 0);
        chk("done_holds", bus.period, 15);

        // constant stream
        step(0, 1, 0, 0); step(0, 0, 1, 4'h5); step(0, 0, 1, 4'h5); step(0, 0, 0, 0);
        chk("const_period", bus.period, 1);
        chk("const_done", bus.done, 1);

        // zero lock-up in COUNT, then in ARM
        step(0, 1, 0, 0); step(0, 0, 1, 4'hF); step(0, 0, 1, 4'h7); step(0, 0, 1, 4'h0);
        step(0, 0, 0, 0);
        chk("zl_count", {bus.zero_lock, bus.done, bus.busy}, 3'b100);
        step(0, 1, 0, 0); step(0, 0, 1, 4'h0); step(0, 0, 0, 0);
        chk("zl_arm", {bus.zero_lock, bus.done, bus.timeout, bus.busy}, 4'b1000);

        // gapped stream
        step(0, 1, 0, 0); run_lfsr(16, 1); step(0, 0, 0, 0);
        chk("gap_period", bus.period, 15);

        // timeout after 31 non-recurring samples
        step(0, 1, 0, 0); step(0, 0, 1, 4'h1);
        for (int i = 0; i < 30; i++) step(0, 0, 1, 4'h2);
        step(0, 0, 0, 0);
        chk("pre_timeout", {bus.timeout, bus.busy}, 2'b01);
        step(0, 0, 1, 4'h2); step(0, 0, 0, 0);
        chk("timeout", {bus.timeout, bus.done, bus.zero_lock, bus.busy}, 4'b1000);
        chk("timeout_period", bus.period, 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        chk("restart_clear", {bus.timeout, bus.done, bus.zero_lock, bus.busy}, 4'b0001);

        // restart mid-count; same-cycle sample ignored
        step(0, 0, 1, 4'h9); step(0, 0, 1, 4'h4); step(0, 1, 1, 4'h9);
        step(0, 0, 1, 4'h3); step(0, 0, 1, 4'h3); step(0, 0, 0, 0);
        chk("restart_period", bus.period, 1);

        // reset during COUNT with cnt=7
        step(0, 1, 0, 0); run_lfsr(8, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        chk("reset_mid", {bus.period, bus.done, bus.zero_lock, bus.timeout, bus.busy}, 0);
        step(0, 1, 0, 0); run_lfsr(16, 0); step(0, 0, 0, 0);
        chk("post_reset_period", bus.period, 15);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
